// File: rtl/fir_filter.sv
// Time-multiplexed single-MAC direct-form FIR filter.
// Each accepted sample enters the delay line, then one tap product is
// accumulated per clock. The saturated 16-bit result is presented on dout
// together with a one-cycle valid_out strobe. The coefficient bank is
// host-writable and keeps its contents across reset.
module fir_filter #(
  parameter int NTAPS = 8,
  parameter int SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] din,
  input  logic               valid_in,
  input  logic signed [19:0] CIN,
  input  logic        [10:0] CADDR,
  input  logic               CLOAD,
  output logic signed [15:0] dout,
  output logic               valid_out
);

  localparam int K_W   = $clog2(NTAPS);
  // Sum of NTAPS full-scale 36-bit products fits without internal overflow.
  localparam int ACC_W = 36 + K_W;

  localparam logic        [K_W-1:0]   K_LAST  = K_W'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t                   state;
  logic        [K_W-1:0]    k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [19:0]       coef [NTAPS];
  logic signed [15:0]       x    [NTAPS];
  logic signed [35:0]       prod;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [15:0]       sat_val;

  // Tap product for the tap currently being accumulated.
  assign prod = coef[k] * x[k];

  // Coefficient bank write port; out-of-range addresses are ignored.
  // NOTE: the coefficient bank is deliberately outside the reset domain, so
  // host writes land even while reset is held and survive a reset pulse.
  always_ff @(posedge clk) begin
    if (CLOAD && (int'(CADDR) < NTAPS)) begin
      coef[CADDR[K_W-1:0]] <= CIN;
    end
  end

  // Scale the accumulator and clamp it to the signed 16-bit output range.
  // NOTE: every variable assigned here gets a value on every path so that no
  // latch is inferred.
  always_comb begin
    acc_shr = acc >>> SHIFT;
    if (acc_shr > SAT_MAX) begin
      sat_val = 16'sh7FFF;
    end else if (acc_shr < SAT_MIN) begin
      sat_val = 16'sh8000;
    end else begin
      sat_val = acc_shr[15:0];
    end
  end

  // Control FSM, delay line, accumulator and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      dout      <= '0;
      valid_out <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        x[i] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          // A coefficient write in the same cycle takes priority over a sample.
          if (valid_in && !CLOAD) begin
            for (int i = NTAPS - 1; i > 0; i--) begin
              x[i] <= x[i-1];
            end
            x[0]  <= din;
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= k + 1'b1;
          if (k == K_LAST) begin
            state <= OUT;
          end
        end
        OUT: begin
          dout      <= sat_val;
          valid_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: reset behaviour, impulse response, step
// response, ignored out-of-range coefficient writes, saturation, output
// scaling, sample dropping while busy, and reset in mid-computation.
module tb_fir_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] din;
  logic               valid_in;
  logic signed [19:0] CIN;
  logic        [10:0] CADDR;
  logic               CLOAD;
  logic signed [15:0] dout;
  logic               valid_out;
  logic signed [15:0] dout_s19;
  logic               valid_out_s19;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fir_filter #(.NTAPS(8), .SHIFT(0)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .valid_in  (valid_in),
    .CIN       (CIN),
    .CADDR     (CADDR),
    .CLOAD     (CLOAD),
    .dout      (dout),
    .valid_out (valid_out)
  );

  // Second build sharing all inputs, used to check output scaling.
  fir_filter #(.NTAPS(8), .SHIFT(19)) u_dut_s19 (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .valid_in  (valid_in),
    .CIN       (CIN),
    .CADDR     (CADDR),
    .CLOAD     (CLOAD),
    .dout      (dout_s19),
    .valid_out (valid_out_s19)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [10:0] addr, input logic signed [19:0] val);
    CADDR = addr;
    CIN   = val;
    CLOAD = 1'b1;
    @(posedge clk); #1;
    CLOAD = 1'b0;
  endtask

  // Present one sample, then wait (bounded) for its result strobe.
  // lat is the number of edges from the accept edge to valid_out (0 = none).
  task automatic send(input logic signed [15:0] d, output logic signed [15:0] res,
                      output logic signed [15:0] res2, output int lat);
    din      = d;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat  = 0;
    res  = 'x;
    res2 = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (valid_out) begin
        lat  = i;
        res  = dout;
        res2 = valid_out_s19 ? dout_s19 : 16'sh0BAD;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [15:0] res;
    logic signed [15:0] res2;
    int lat;
    int vcnt;
    int dcnt;

    reset = 1'b1; din = '0; valid_in = 1'b0; CIN = '0; CADDR = '0; CLOAD = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state; coefficients k+1 loaded while reset is held.
    for (int i = 0; i < 8; i++) load(11'(i), 20'(i + 1));
    check("rst_dout", dout, 0);
    check("rst_valid_out", valid_out, 0);
    reset = 1'b0;

    // Idle with no samples: nothing may appear.
    vcnt = 0; dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (valid_out !== 1'b0) vcnt++;
      if (dout !== 16'sd0) dcnt++;
    end
    check("idle_valid_cnt", vcnt, 0);
    check("idle_dout_cnt", dcnt, 0);

    // Impulse response reads out the coefficients, 9-edge latency.
    for (int i = 0; i < 9; i++) begin
      send((i == 0) ? 16'sd1 : 16'sd0, res, res2, lat);
      check($sformatf("imp_out%0d", i), res, (i < 8) ? i + 1 : 0);
      check($sformatf("imp_lat%0d", i), lat, 9);
    end

    // Step response with unity coefficients.
    for (int i = 0; i < 8; i++) load(11'(i), 20'sd1);
    for (int i = 1; i <= 9; i++) begin
      send(16'sd100, res, res2, lat);
      check($sformatf("step_out%0d", i), res, (i <= 8) ? 100 * i : 800);
    end

    // Out-of-range coefficient writes must be ignored.
    for (int a = 8; a < 2048; a++) load(11'(a), 20'sd5);
    send(16'sd100, res, res2, lat);
    check("oor_write_out", res, 800);

    // Saturation, positive then negative.
    load(11'd0, 20'h7FFFF);
    load(11'd1, 20'h7FFFF);
    for (int i = 2; i < 8; i++) load(11'(i), 20'sd0);
    send(16'sd32767, res, res2, lat);
    check("sat_pos_a", res, 32767);
    send(16'sd32767, res, res2, lat);
    check("sat_pos_b", res, 32767);
    send(-16'sd32768, res, res2, lat);
    check("sat_neg_a", res, -32768);
    send(-16'sd32768, res, res2, lat);
    check("sat_neg_b", res, -32768);

    // Scaling: 1000 * 2^18 = 262144000; >>>19 gives 500, unscaled saturates.
    load(11'd0, 20'sd262144);
    load(11'd1, 20'sd0);
    send(16'sd1000, res, res2, lat);
    check("shift0_out", res, 32767);
    check("shift19_out", res2, 500);

    // Samples arriving while busy are dropped.
    for (int i = 0; i < 8; i++) load(11'(i), 20'(i + 1));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    din = 16'sd7; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    din = 16'sd50; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    din = 16'sd60; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    vcnt = 0; res = 'x;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (valid_out) begin
        vcnt++;
        if (vcnt == 1) res = dout;
      end
    end
    check("drop_valid_cnt", vcnt, 1);
    check("drop_first_out", res, 7);
    send(16'sd0, res, res2, lat);
    check("drop_history", res, 14);

    // Reset four edges into a computation aborts it.
    din = 16'sd1; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (valid_out) vcnt++;
    end
    reset = 1'b1;
    #1;
    check("abort_rst_dout", dout, 0);
    check("abort_rst_valid", valid_out, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (valid_out) vcnt++;
    end
    check("abort_valid_cnt", vcnt, 0);
    check("abort_dout", dout, 0);

    // Coefficients retained, history cleared: impulse response repeats.
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 16'sd1 : 16'sd0, res, res2, lat);
      check($sformatf("reimp_out%0d", i), res, i + 1);
      check($sformatf("reimp_lat%0d", i), lat, 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_filter.md
Name: fir_filter

Overview:
Time-multiplexed, single-MAC, direct-form FIR filter with a run-time loadable coefficient bank.
- Each accepted 16-bit input sample is shifted into a delay line.
- One tap product is accumulated per clock.
- A saturated 16-bit result is emitted with a one-cycle valid strobe.
- Sits between a sample source and sink that run at a rate of at most one sample per NTAPS+2 clocks.
- Coefficients are written by a host via an address/data/load port.

Parameters:
NTAPS, 8, number of filter taps (coefficient bank and delay line depth), 2..2048
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
din  input  16  signed two's-complement input sample
valid_in  input  1  din is valid this cycle (single-cycle strobe)
CIN  input  20  signed coefficient write data
CADDR  input  11  coefficient write address (tap index)
CLOAD  input  1  coefficient write enable
dout  output  16  signed filter output
valid_out  output  1  one-cycle strobe, dout holds a new result

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset (asynchronous, active-high):
  - Clears the delay line, accumulator, tap counter, FSM (to IDLE), dout=0 and valid_out=0.
  - Does NOT clear the coefficient bank.
- Coefficient write:
  - On a rising edge with CLOAD=1 and CADDR<NTAPS: coef[CADDR] <= CIN.
  - Writes are honoured even while reset is asserted.
  - CADDR>=NTAPS: the write is ignored.
- CLOAD has priority: while CLOAD=1, valid_in is ignored.
- FSM states: IDLE, MAC, OUT.
  - IDLE: on an edge with valid_in=1 and CLOAD=0:
    - x[k] <= x[k-1] for k=1..NTAPS-1; x[0] <= din.
    - acc <= 0, k <= 0, go to MAC.
  - MAC: each edge, acc <= acc + coef[k]*x[k], k <= k+1.
    - After the edge that accumulates k=NTAPS-1, go to OUT.
    - This makes NTAPS accumulate edges.
  - OUT: dout <= sat16(acc >>> SHIFT), valid_out <= 1, go to IDLE.
  - valid_out is 0 in every other cycle.
- Latency:
  - Sample accepted at edge T; valid_out/dout update at edge T+NTAPS+1.
  - Next sample can be accepted at edge T+NTAPS+2 or later.
- valid_in asserted while in MAC or OUT: the sample is dropped. The delay line is unchanged and no output is produced for it.
- Arithmetic:
  - Product is 16x20 signed = 36 bits.
  - Accumulator is 36+ceil(log2(NTAPS)) bits and cannot overflow internally.
  - sat16 clamps to [-32768, 32767].
- dout holds its last value between valid_out strobes.
- Coefficient writes during MAC are allowed. They take effect for any tap not yet accumulated; the source is responsible for avoiding this if consistency is needed.
- Reset mid-MAC aborts the computation: no valid_out, history cleared, coefficients retained.

Test Plan:
1. Reset, then idle 20 cycles -> dout=0 and valid_out=0 throughout; valid_out stays 0 with no valid_in.
2. Load coef[k]=k+1 (k=0..7) during reset, release reset, send impulse (1 then seven 0s, one per 10 clocks) -> outputs 1,2,3,4,5,6,7,8, then 0. Each valid_out occurs exactly 9 clocks after its valid_in edge.
3. All coef=1, feed din=100 continuously every 10 clocks -> outputs 100,200,...,800, then steady 800. Also write CADDR=8..2047 with CIN=5 -> outputs unchanged.
4. Saturation:
   - coef[0]=coef[1]=20'h7FFFF (others 0), din=32767 twice -> 32767.
   - din=-32768 twice -> -32768.
   - SHIFT=19 build, coef[0]=2^18 (0.5), din=1000 -> 500.
5. valid_in pulses 3 clocks apart -> only the first is accepted, exactly one valid_out; the next history contains only the first sample.
6. Assert reset 4 clocks after valid_in -> no valid_out, dout=0. Next impulse reproduces the scenario-2 sequence from its start with coefficients intact.
